fetch_stage: RTL

- Fetch stage plus F/D pipeline buffer; sits directly upstream of the decode-stage control unit and consumes its fetch-control outputs: pc_enable, f_d_buffer_enable, flush, jump_sel.
- Holds the PC, addresses instruction memory, and selects the next PC from five sources: sequential, decode jump, interrupt vector, popped return address, or execute-stage branch.
- Assembles 32-bit return addresses from two 16-bit stack pops.
- Latches asynchronous interrupt requests and presents them to decode.

---
 rtl/fetch_stage.sv | 100 ++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// Fetch stage with F/D pipeline buffer: PC register and next-PC selection,
// return-address assembly from stack pops, and the pending-interrupt latch.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR = 32'h0000_0002,
  parameter logic [15:0] NOP_WORD   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_enable,
  input  logic        f_d_buffer_enable,
  input  logic        flush,
  input  logic [1:0]  jump_sel,
  input  logic [31:0] jump_target,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        pop_valid,
  input  logic        pop_high,
  input  logic [15:0] pop_data,
  input  logic        interrupt,
  input  logic        int_ack,
  output logic [31:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [31:0] pc,
  output logic [15:0] instr_fd,
  output logic [31:0] pc_fd,
  output logic        interrupt_fd
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned HLEN = 16;

  logic [XLEN-1:0] ret_pc;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] pc_next;

  assign imem_addr = pc;
  assign pc_inc    = pc + XLEN'(1);

  // Next-PC select; a taken branch belongs to an older instruction and overrides stalls
  always_comb begin
    pc_next = pc;
    if (branch_taken) begin
      pc_next = branch_target;
    end else if (pc_enable) begin
      unique case (jump_sel)
        2'b00:   pc_next = pc_inc;
        2'b01:   pc_next = jump_target;
        2'b10:   pc_next = INT_VECTOR;
        default: pc_next = ret_pc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

  // Return address built from two 16-bit pops; a same-edge RET load sees the old value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ret_pc <= '0;
    end else if (pop_valid) begin
      if (pop_high) begin
        ret_pc[XLEN-1:HLEN] <= pop_data;
      end else begin
        ret_pc[HLEN-1:0] <= pop_data;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_fd <= NOP_WORD;
      pc_fd    <= '0;
    end else if (branch_taken || flush) begin
      instr_fd <= NOP_WORD;
      pc_fd    <= '0;
    end else if (f_d_buffer_enable) begin
      instr_fd <= imem_data;
      pc_fd    <= pc_inc;
    end
  end

  // A new request wins over a same-edge acknowledge so it is never dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      interrupt_fd <= 1'b0;
    end else if (interrupt) begin
      interrupt_fd <= 1'b1;
    end else if (int_ack) begin
      interrupt_fd <= 1'b0;
    end
  end

endmodule
